// File: rtl/snax_reshuffler_csr_pkg.sv
// Shared types and address-map helpers for the reshuffler CSR manager.
// Holds the launch FSM states, status bit positions and offset functions.
package snax_reshuffler_csr_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_e;

  localparam int unsigned STAT_PENDING = 0;
  localparam int unsigned STAT_BUSY    = 1;

  function automatic int unsigned launch_off(
    input int unsigned rw
  );
    return rw;
  endfunction

  function automatic int unsigned ro_base(
    input int unsigned rw
  );
    return rw + 1;
  endfunction

  function automatic int unsigned perf_off(
    input int unsigned rw,
    input int unsigned ro
  );
    return rw + ro + 1;
  endfunction

endpackage

// File: rtl/snax_reshuffler_csr_manager_if.sv
// Core-side CSR request/response bus of the reshuffler CSR manager.
// master = core (drives requests), slave = manager (drives responses).
interface snax_reshuffler_csr_manager_if #(
  parameter int unsigned RegDataWidth = 32,
  parameter int unsigned RegAddrWidth = 32
) ();

  logic [RegAddrWidth-1:0] csr_req_addr_i;
  logic [RegDataWidth-1:0] csr_req_data_i;
  logic                    csr_req_write_i;
  logic                    csr_req_valid_i;
  logic                    csr_req_ready_o;
  logic [RegDataWidth-1:0] csr_rsp_data_o;
  logic                    csr_rsp_valid_o;
  logic                    csr_rsp_ready_i;

  modport master (
    output csr_req_addr_i,
    output csr_req_data_i,
    output csr_req_write_i,
    output csr_req_valid_i,
    input  csr_req_ready_o,
    input  csr_rsp_data_o,
    input  csr_rsp_valid_o,
    output csr_rsp_ready_i
  );

  modport slave (
    input  csr_req_addr_i,
    input  csr_req_data_i,
    input  csr_req_write_i,
    input  csr_req_valid_i,
    output csr_req_ready_o,
    output csr_rsp_data_o,
    output csr_rsp_valid_o,
    input  csr_rsp_ready_i
  );

endinterface

// File: rtl/snax_reshuffler_csr_manager.sv
// CSR manager: shadow RW regs, launch snapshot handshake, RO/status reads.
// Ports: clk_i, rst_ni, csr (slave bus), csr_reg_set_o/valid_o/ready_i,
// csr_reg_ro_set_i. Optional SNAX_RESHUFFLER_CSR_PERF_COUNTER_EN adds a
// saturating busy-cycle counter readable at the PERF offset.
module snax_reshuffler_csr_manager
  import snax_reshuffler_csr_pkg::*;
#(
  parameter int unsigned RegRWCount   = 2,
  parameter int unsigned RegROCount   = 2,
  parameter int unsigned RegDataWidth = 32,
  parameter int unsigned RegAddrWidth = 32
) (
  input  logic clk_i,
  input  logic rst_ni,
  snax_reshuffler_csr_manager_if.slave csr,
  output logic [RegRWCount-1:0][RegDataWidth-1:0] csr_reg_set_o,
  output logic                                    csr_reg_set_valid_o,
  input  logic                                    csr_reg_set_ready_i,
  input  logic [RegROCount-1:0][RegDataWidth-1:0] csr_reg_ro_set_i
);

  localparam logic [RegAddrWidth-1:0] LAUNCH_A =
    RegAddrWidth'(launch_off(RegRWCount));
  localparam logic [RegAddrWidth-1:0] RO_A =
    RegAddrWidth'(ro_base(RegRWCount));

  state_e r_state;
  state_e w_state_nxt;

  logic [RegRWCount-1:0][RegDataWidth-1:0] r_shadow;
  logic [RegRWCount-1:0][RegDataWidth-1:0] r_set;
  logic                    r_rsp_valid;
  logic [RegDataWidth-1:0] r_rsp_data;
  logic [RegDataWidth-1:0] w_rdata;

  logic w_is_launch;
  logic w_rsp_stall;
  logic w_launch_blk;
  logic w_req_ready;
  logic w_acc;
  logic w_wr;
  logic w_rd;
  logic w_launch;

  assign w_is_launch  = csr.csr_req_addr_i == LAUNCH_A;
  assign w_rsp_stall  = r_rsp_valid & ~csr.csr_rsp_ready_i;
  // A second launch must wait for the pending snapshot to be taken.
  assign w_launch_blk = csr.csr_req_write_i & w_is_launch
                      & (r_state == PENDING);
  assign w_req_ready  = ~w_rsp_stall & ~w_launch_blk;
  assign w_acc        = csr.csr_req_valid_i & w_req_ready;
  assign w_wr         = w_acc & csr.csr_req_write_i;
  assign w_rd         = w_acc & ~csr.csr_req_write_i;
  assign w_launch     = w_wr & w_is_launch;

  assign csr.csr_req_ready_o = w_req_ready;
  assign csr.csr_rsp_valid_o = r_rsp_valid;
  assign csr.csr_rsp_data_o  = r_rsp_data;
  assign csr_reg_set_o       = r_set;

`ifdef SNAX_RESHUFFLER_CSR_PERF_COUNTER_EN
  localparam logic [RegAddrWidth-1:0] PERF_A =
    RegAddrWidth'(perf_off(RegRWCount, RegROCount));

  logic [31:0] r_perf;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_perf <= '0;
    end else if (w_launch) begin
      r_perf <= '0;
    end else if (!csr_reg_set_ready_i && r_perf != '1) begin
      r_perf <= r_perf + 32'd1;
    end
  end
`endif

  always_comb begin
    w_state_nxt         = r_state;
    csr_reg_set_valid_o = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_launch) w_state_nxt = PENDING;
      end
      PENDING: begin
        csr_reg_set_valid_o = 1'b1;
        if (csr_reg_set_ready_i) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < RegRWCount; i++) begin
      if (csr.csr_req_addr_i == RegAddrWidth'(i)) w_rdata = r_shadow[i];
    end
    if (w_is_launch) begin
      w_rdata[STAT_PENDING] = r_state == PENDING;
      w_rdata[STAT_BUSY]    = ~csr_reg_set_ready_i;
    end
    for (int j = 0; j < RegROCount; j++) begin
      if (csr.csr_req_addr_i == RO_A + RegAddrWidth'(j)) begin
        w_rdata = csr_reg_ro_set_i[j];
      end
    end
`ifdef SNAX_RESHUFFLER_CSR_PERF_COUNTER_EN
    if (csr.csr_req_addr_i == PERF_A) w_rdata = RegDataWidth'(r_perf);
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= IDLE;
      r_shadow <= '0;
      r_set    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_launch) r_set <= r_shadow;
      for (int i = 0; i < RegRWCount; i++) begin
        if (w_wr && csr.csr_req_addr_i == RegAddrWidth'(i)) begin
          r_shadow[i] <= csr.csr_req_data_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else if (w_rd) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= w_rdata;
    end else if (csr.csr_rsp_ready_i) begin
      r_rsp_valid <= 1'b0;
    end
  end

endmodule
